// File: rtl/addsub_accum.sv
// Registered add/subtract accumulator with wrap or saturate/reject modes.
// Results and flags leave through a one-entry valid/ready output stage.
module addsub_accum #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry_borrow,
    output logic             clamp,
    output logic             reject,
    output logic             zero
);

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpAdd   = 2'b01;
    localparam logic [1:0] OpSub   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cb_q, cb_d;
    logic             clamp_q, clamp_d;
    logic             reject_q, reject_d;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    assign out_valid    = (state_q == StFull);
    assign in_ready     = rst_n & (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;

    assign acc          = acc_q;
    assign carry_borrow = cb_q;
    assign clamp        = clamp_q;
    assign reject       = reject_q;
    assign zero         = (acc_q == '0);

    // Sum keeps the carry so saturation sees overflow past 2**WIDTH as well.
    assign sum    = {1'b0, acc_q} + {1'b0, operand};
    assign diff   = acc_q - operand;
    assign borrow = (operand > acc_q);

    always_comb begin
        acc_d    = acc_q;
        cb_d     = 1'b0;
        clamp_d  = 1'b0;
        reject_d = 1'b0;
        unique case (op)
            OpLoad: begin
                if (sat && (operand > MAX_VAL)) begin
                    acc_d   = MAX_VAL;
                    clamp_d = 1'b1;
                end else begin
                    acc_d = operand;
                end
            end
            OpAdd: begin
                cb_d = sum[WIDTH];
                if (sat && (sum > {1'b0, MAX_VAL})) begin
                    acc_d   = MAX_VAL;
                    clamp_d = 1'b1;
                end else begin
                    acc_d = sum[WIDTH-1:0];
                end
            end
            OpSub: begin
                cb_d = borrow;
                if (sat && borrow) begin
                    reject_d = 1'b1;
                end else begin
                    acc_d = diff;
                end
            end
            OpClear: begin
                acc_d = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StFull;
        end else if (out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            acc_q    <= '0;
            cb_q     <= 1'b0;
            clamp_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q    <= acc_d;
                cb_q     <= cb_d;
                clamp_q  <= clamp_d;
                reject_q <= reject_d;
            end
        end
    end

endmodule

// File: tb/tb_addsub_accum.sv
// Directed-vector bench for addsub_accum at WIDTH=8, MAX_VAL=200.
module tb_addsub_accum;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry_borrow;
    logic             clamp;
    logic             reject;
    logic             zero;

    int n_vec = 0;
    int n_err = 0;

    addsub_accum #(
        .WIDTH   (WIDTH),
        .MAX_VAL (8'd200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .operand      (operand),
        .sat          (sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .acc          (acc),
        .carry_borrow (carry_borrow),
        .clamp        (clamp),
        .reject       (reject),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge; block must be ready.
    task automatic do_cmd(input logic [1:0] o, input logic [7:0] v, input logic s);
        in_valid = 1'b1;
        op       = o;
        operand  = v;
        sat      = s;
        #1;
        check("cmd_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] a, input logic cb,
                              input logic cl, input logic rj);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_acc"}, 32'(acc), 32'(a));
        check({tag, "_cb"}, 32'(carry_borrow), 32'(cb));
        check({tag, "_clamp"}, 32'(clamp), 32'(cl));
        check({tag, "_reject"}, 32'(reject), 32'(rj));
        check({tag, "_zero"}, 32'(zero), 32'(a == 8'd0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b01;
        operand   = 8'd5;
        sat       = 1'b0;
        out_ready = 1'b1;

        // Reset with a command waiting: it must be dropped.
        #1;
        check("rst_ready0", 32'(in_ready), 0);
        tick();
        check("rst_ready1", 32'(in_ready), 0);
        tick();
        check("rst_ready2", 32'(in_ready), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_zero", 32'(zero), 1);
        check("rst_cb", 32'(carry_borrow), 0);
        check("rst_clamp", 32'(clamp), 0);
        check("rst_reject", 32'(reject), 0);
        check("rst_valid", 32'(out_valid), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_valid", 32'(out_valid), 0);

        // Saturating add and load
        do_cmd(2'b00, 8'd150, 1'b1);
        expect_out("load150", 8'd150, 1'b0, 1'b0, 1'b0);
        do_cmd(2'b01, 8'd80, 1'b1);
        expect_out("sadd80", 8'd200, 1'b0, 1'b1, 1'b0);
        do_cmd(2'b00, 8'd230, 1'b1);
        expect_out("sload230", 8'd200, 1'b0, 1'b1, 1'b0);

        // Wrapping add
        do_cmd(2'b00, 8'd230, 1'b0);
        expect_out("wload230", 8'd230, 1'b0, 1'b0, 1'b0);
        do_cmd(2'b01, 8'd50, 1'b0);
        expect_out("wadd50", 8'd24, 1'b1, 1'b0, 1'b0);

        // Clear in saturate mode
        do_cmd(2'b11, 8'd99, 1'b1);
        expect_out("clear", 8'd0, 1'b0, 1'b0, 1'b0);

        // Underflow handling
        do_cmd(2'b00, 8'd30, 1'b0);
        expect_out("load30", 8'd30, 1'b0, 1'b0, 1'b0);
        do_cmd(2'b10, 8'd45, 1'b1);
        expect_out("ssub45", 8'd30, 1'b1, 1'b0, 1'b1);
        do_cmd(2'b10, 8'd45, 1'b0);
        expect_out("wsub45", 8'd241, 1'b1, 1'b0, 1'b0);
        do_cmd(2'b00, 8'd45, 1'b1);
        expect_out("load45", 8'd45, 1'b0, 1'b0, 1'b0);
        do_cmd(2'b10, 8'd45, 1'b1);
        expect_out("ssub_eq", 8'd0, 1'b0, 1'b0, 1'b0);

        // Drain, then backpressure
        tick();
        check("drain_valid", 32'(out_valid), 0);
        out_ready = 1'b0;
        do_cmd(2'b01, 8'd5, 1'b0);
        expect_out("bp_add5", 8'd5, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        op       = 2'b01;
        operand  = 8'd7;
        sat      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(in_ready), 0);
            tick();
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_acc", 32'(acc), 5);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        tick();
        check("bp_add7_valid", 32'(out_valid), 1);
        check("bp_add7_acc", 32'(acc), 12);

        // Back-to-back: one result per cycle
        begin
            logic [7:0] exp_acc;
            exp_acc = 8'd12;
            for (int i = 1; i <= 4; i++) begin
                operand = 8'(i);
                exp_acc = exp_acc + 8'(i);
                #1;
                check("b2b_ready", 32'(in_ready), 1);
                tick();
                check("b2b_valid", 32'(out_valid), 1);
                check("b2b_acc", 32'(acc), 32'(exp_acc));
            end
        end
        in_valid = 1'b0;
        tick();
        check("b2b_empty", 32'(out_valid), 0);
        check("b2b_persist", 32'(acc), 22);

        // Reset while FULL discards the pending result
        out_ready = 1'b0;
        do_cmd(2'b01, 8'd10, 1'b0);
        expect_out("mid_add10", 8'd32, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_acc", 32'(acc), 0);
        check("mid_rst_zero", 32'(zero), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_stale", 32'(out_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_accum.md
# addsub_accum

Parametrised, registered add/subtract accumulator for the arithmetic section of the vending datapath. It holds a WIDTH-bit running value, such as inserted credit. Each accepted command loads, adds to, subtracts from, or clears that value, in either wrap or saturate/reject mode. Results and status flags leave through a one-entry valid/ready output stage with backpressure.

## Interface
- WIDTH, default 8: accumulator and operand width, ≥2.
- MAX_VAL, default 2**WIDTH-1: saturation ceiling in saturate mode, ≤ 2**WIDTH-1.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command this cycle.
- op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- operand  in  WIDTH  unsigned operand; ignored for CLEAR.
- sat  in  1  1 = saturate/reject mode, 0 = wrap mode; sampled with the command.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- acc  out  WIDTH  accumulator value after the last accepted command.
- carry_borrow  out  1  ADD: raw carry out of bit WIDTH-1. SUB: raw borrow (operand > acc). Otherwise 0.
- clamp  out  1  result forced to MAX_VAL.
- reject  out  1  SUB refused; acc unchanged.
- zero  out  1  acc == 0.

## Operation
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = rst_n & (~out_valid | out_ready), combinational.
- Accept = in_valid & in_ready.
  - On accept: acc and flags update at that edge, and the state becomes FULL.
  - FULL with out_ready=1 and no accept: the state becomes EMPTY.
- Arithmetic is done at WIDTH+1 bits, with a = acc and b = operand.
  - ADD: s = a + b. carry_borrow = s[WIDTH].
  - SUB: d = a + ~b + 1. carry_borrow = (b > a).
- Wrap mode (sat=0):
  - ADD: acc = s[WIDTH-1:0].
  - SUB: acc = d[WIDTH-1:0], i.e. modulo 2**WIDTH.
  - LOAD: acc = operand.
  - clamp=0 and reject=0. MAX_VAL is ignored.
- Saturate mode (sat=1):
  - ADD: if s > MAX_VAL (carry included), acc = MAX_VAL and clamp=1; else acc = s.
  - SUB: if b > a, acc is unchanged and reject=1; else acc = a - b.
  - LOAD: if operand > MAX_VAL, acc = MAX_VAL and clamp=1; else acc = operand.
- CLEAR: acc=0 and carry_borrow=clamp=reject=0, in either mode.
- zero always reflects the registered acc. That includes an unchanged acc after a reject.
- Flags carry_borrow, clamp and reject describe the most recent accepted command only. They are registered with acc.

## Timing
- Reset:
  - Any edge with rst_n=0 forces acc=0, carry_borrow=0, clamp=0, reject=0, zero=1, out_valid=0.
  - in_ready=0 while rst_n=0.
  - Commands presented during reset are dropped.
  - Reset while FULL discards the pending result; no handshake completes.
- Latency is 1 cycle: a command accepted at edge N gives out_valid=1 with its result after edge N.
- Outputs are stable while out_valid=1 and out_ready=0:
  - acc, flags and out_valid hold.
  - in_ready=0, so no command is accepted.
- Simultaneous FULL & out_ready & in_valid:
  - The old result is consumed and the new command is accepted on the same edge.
  - out_valid stays 1 and shows the new result.
  - Throughput is one command per cycle.
- acc persists across handshakes. It reflects the last accepted command even while EMPTY.
- Mode is per command; switching sat between commands needs no idle cycle.

## Test plan
All tests use WIDTH=8, MAX_VAL=200.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1.
  - During reset: in_ready=0.
  - After: acc=0, zero=1, all other flags 0, out_valid=0.
  - One cycle after release: in_ready=1.
- Saturate add: LOAD 150 (sat=1), then ADD 80 (sat=1).
  - Result: acc=200, clamp=1, carry_borrow=0.
  - Then LOAD 230 (sat=1): acc=200, clamp=1.
- Wrap add: LOAD 230 (sat=0), then ADD 50 (sat=0).
  - Result: acc=24, carry_borrow=1, clamp=0.
- Underflow: LOAD 30.
  - SUB 45 (sat=1): acc=30, reject=1, carry_borrow=1, zero=0.
  - Then SUB 45 (sat=0): acc=241, reject=0, carry_borrow=1.
  - Then LOAD 45, SUB 45 (sat=1): acc=0, zero=1, carry_borrow=0.
- Backpressure: issue ADD 5 with out_ready=0.
  - out_valid stays 1 and acc stays fixed for 3 cycles.
  - in_ready=0, and a waiting ADD 7 is not accepted.
  - Raise out_ready: ADD 7 is accepted that edge, and out_valid stays 1 with acc +7.
  - Back-to-back 4 commands at out_ready=1: 4 results on 4 consecutive cycles.
- Reset mid-operation: hold a result FULL with out_ready=0, then pulse rst_n=0 for 1 cycle.
  - Next cycle: out_valid=0, acc=0, zero=1.
  - The stale result is never handshaken.
